param_dmem: RTL
===============

PARAM_DMEM -- requirements
Module: param_dmem

Interface
REQ-001 SHALL have parameter DSIZE, default 16: data word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter AW, default 9: word-address width; DEPTH = 2**AW words (512 by default).
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter INIT_CLEAR, default 1: when 1, zero-fill the array after reset.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (asserted when 0).
REQ-007 SHALL have port req, input, 1 bit: request strobe.
REQ-008 SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port be, input, DSIZE/8 bits: byte-lane write enables.
REQ-010 SHALL have port addr, input, DSIZE bits: word address.
REQ-011 SHALL have port wdata, input, DSIZE bits: write data.
REQ-012 SHALL have port ready, output, 1 bit: request acceptance.
REQ-013 SHALL have port busy, output, 1 bit: reset or clear sequence in progress.
REQ-014 SHALL have port rvalid, output, 1 bit: read response strobe.
REQ-015 SHALL have port rdata, output, DSIZE bits: read data.
REQ-016 SHALL have port err, output, 1 bit: out-of-range response strobe.

Function
REQ-017 SHALL implement FSM states RST, CLEAR, RUN.
REQ-018 SHALL leave RST, on the first edge with rst=1, for CLEAR if INIT_CLEAR=1, else for RUN.
REQ-019 In CLEAR, SHALL write zero to word k in the k-th cycle (k = 0..DEPTH-1), then enter RUN on the next edge; busy=1 and ready=0 throughout CLEAR.
REQ-020 In RUN, SHALL hold ready=1 and busy=0; a request is accepted when req=1 and ready=1 at a rising edge; up to one request per cycle, back-to-back allowed.
REQ-021 SHALL ignore req when ready=0: no state change, no response.
REQ-022 An accepted write SHALL update only the byte lanes whose be bit is 1; be=0 is accepted as a no-op; a write produces no rvalid.
REQ-023 An accepted read SHALL pulse rvalid for exactly one cycle, RD_LAT cycles after acceptance, with rdata holding the addressed word during that cycle.
REQ-024 rdata SHALL hold its last value while rvalid=0.
REQ-025 A read accepted in the cycle after a write to the same address SHALL return the newly written data (write-then-read ordering).
REQ-026 An address with any bit at or above position AW set is out of range.
REQ-027 An out-of-range write SHALL be dropped.
REQ-028 An out-of-range read SHALL return rdata=0 with rvalid=1.
REQ-029 For any out-of-range request, err SHALL pulse for one cycle, RD_LAT cycles after acceptance.
REQ-030 With RD_LAT=2, SHALL sustain one read response per cycle (fully pipelined), with responses in request order.

Reset
REQ-031 While rst=0: ready=0, busy=1, rvalid=0, err=0, rdata=0; FSM in RST; clear counter=0.
REQ-032 rst=0 during CLEAR SHALL abort the sweep; the sweep restarts at word 0 after release.
REQ-033 rst=0 with reads in flight SHALL flush the response pipeline; no rvalid or err from pre-reset requests SHALL appear after release.
REQ-034 Array contents SHALL NOT be altered by reset itself; they are cleared only by CLEAR and are otherwise undefined.

Structure
REQ-035 Shared package dmem_pkg SHALL hold the FSM state type, the default DSIZE/AW constants, and the RD_LAT legal range.
REQ-036 SHALL use one sub-module, dmem_rsp_pipe: an RD_LAT-deep valid/err/data response shift pipeline with flush.
REQ-037 The array, byte-lane write logic, FSM and clear counter SHALL live in param_dmem.

Verification
REQ-038 Reset release, INIT_CLEAR=1, AW=4 -> busy=1 and ready=0 for exactly 16 cycles, then ready=1; a read of every address returns 0.
REQ-039 Write 0xABCD to addr 3 with be=2'b01, then read addr 3 (previously 0x1234) -> rdata=0x12CD with rvalid RD_LAT cycles after the read.
REQ-040 RD_LAT=2: reads of addr 1,2,3 on consecutive cycles -> three consecutive rvalid cycles with data in request order.
REQ-041 AW=9: read addr 0x0200 -> rvalid=1, err=1, rdata=0; write 0x0200 -> err pulse only, array unchanged.
REQ-042 Assert rst=0 mid-CLEAR and again with two reads in flight -> no stray rvalid; after release the full sweep repeats.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and parameter defaults for param_dmem.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_RST,
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam int DSIZE_DEF  = 16;
    localparam int AW_DEF     = 9;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/dmem_rsp_pipe.sv
// dmem_rsp_pipe: LAT-deep valid/err/data response shift pipeline with synchronous flush.
module dmem_rsp_pipe #(
    parameter int DW  = 16,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          in_err,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic          out_err,
    output logic [DW-1:0] out_data
);

    logic [LAT-1:0] v_q, v_d, e_q, e_d;
    logic [DW-1:0]  d_q [LAT];
    logic [DW-1:0]  d_d [LAT];

    always_comb begin
        v_d = LAT'({v_q, in_valid});
        e_d = LAT'({e_q, in_err});
        d_d[0] = in_data;
        for (int i = 1; i < LAT; i++)
            d_d[i] = d_q[i-1];
        // last stage only loads on a real response so rdata holds between reads
        if (!v_d[LAT-1])
            d_d[LAT-1] = d_q[LAT-1];
        if (flush) begin
            v_d = '0;
            e_d = '0;
            for (int i = 0; i < LAT; i++)
                d_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        v_q <= v_d;
        e_q <= e_d;
        d_q <= d_d;
    end

    assign out_valid = v_q[LAT-1];
    assign out_err   = e_q[LAT-1];
    assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/param_dmem.sv
// param_dmem: parameterised byte-lane data memory with post-reset clear sweep and pipelined reads.
module param_dmem
    import dmem_pkg::*;
#(
    parameter int DSIZE      = DSIZE_DEF,
    parameter int AW         = AW_DEF,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               we,
    input  logic [DSIZE/8-1:0] be,
    input  logic [DSIZE-1:0]   addr,
    input  logic [DSIZE-1:0]   wdata,
    output logic               ready,
    output logic               busy,
    output logic               rvalid,
    output logic [DSIZE-1:0]   rdata,
    output logic               err
);

    localparam int NB    = DSIZE / 8;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_q, clr_d;
    logic [DSIZE-1:0] mem [DEPTH];

    logic            run, acc, oor, wr_en, clr_we;
    logic [AW-1:0]   idx;
    logic            p_valid, p_err;
    logic [DSIZE-1:0] p_data;

    assign run    = rst && state_q == ST_RUN;
    assign acc    = req && run;
    assign oor    = (addr >> AW) != '0;
    assign idx    = addr[AW-1:0];
    assign wr_en  = acc && we && !oor;
    assign clr_we = rst && state_q == ST_CLEAR;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        case (state_q)
            ST_RST: begin
                state_d = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
                clr_d   = '0;
            end
            ST_CLEAR: begin
                clr_d   = clr_q + 1'b1;
                state_d = (&clr_q) ? ST_RUN : ST_CLEAR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_RST;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // array has no reset: contents only change through the sweep or accepted writes
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_q] <= '0;
        else if (wr_en)
            for (int b = 0; b < NB; b++)
                if (be[b])
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end

    dmem_rsp_pipe #(
        .DW  (DSIZE),
        .LAT (LAT)
    ) u_rsp_pipe (
        .clk       (clk),
        .flush     (!rst),
        .in_valid  (acc && !we),
        .in_err    (acc && oor),
        .in_data   (oor ? '0 : mem[idx]),
        .out_valid (p_valid),
        .out_err   (p_err),
        .out_data  (p_data)
    );

    assign ready  = run;
    assign busy   = !run;
    assign rvalid = rst && p_valid;
    assign err    = rst && p_err;
    assign rdata  = rst ? p_data : '0;

endmodule
